// File: rtl/ald_cycle_sequencer.sv
// ald_cycle_sequencer
// Sequences one atomic-layer-deposition run: precursor pulse, precursor wait,
// vacuum purge, water pulse, water wait, water purge, repeated for a latched
// number of cycles. A single phase timer counts 1 kHz ticks and is shared by
// all six timed phases. Valve, busy, done and fault outputs are registered and
// decoded from the next state, so they line up with the state register.
//
// Optional feature: define ALD_SEQ_HOLD_EN to add a 'hold' input that freezes
// the phase timer and closes the precursor/water valves while asserted.
module ald_cycle_sequencer #(
  parameter int TIMER_W = 32,
  parameter int CYCLE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
`ifdef ALD_SEQ_HOLD_EN
  input  logic               hold,
`endif
  input  logic [1:0]         prec_sel,
  input  logic [TIMER_W-1:0] t_on,
  input  logic [TIMER_W-1:0] t_wait,
  input  logic [TIMER_W-1:0] t_vac,
  input  logic [TIMER_W-1:0] t_water,
  input  logic [TIMER_W-1:0] t_waitw,
  input  logic [TIMER_W-1:0] t_vacw,
  input  logic [CYCLE_W-1:0] cycles,
  output logic [2:0]         valve_prec,
  output logic               valve_water,
  output logic               valve_vac,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [CYCLE_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE, P_ON, P_WAIT, P_VAC, W_ON, W_WAIT, W_VAC, FIN
  } state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] phase_cnt, preset;
  logic [TIMER_W-1:0] t_on_q, t_wait_q, t_vac_q, t_water_q, t_waitw_q, t_vacw_q;
  logic [CYCLE_W-1:0] cycles_q, cycle_count_inc;
  logic [1:0]         sel_q, sel_nxt;
  logic               hold_i, timed, phase_exit;
  logic               run_load, zero_run, cycle_inc, fault_nxt;

`ifdef ALD_SEQ_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  assign cycle_count_inc = cycle_count + CYCLE_W'(1);
  assign sel_nxt         = run_load ? prec_sel : sel_q;

  // Select the latched preset of the current phase and detect phase exit.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    preset = '0;
    timed  = 1'b1;
    unique case (state)
      P_ON:    preset = t_on_q;
      P_WAIT:  preset = t_wait_q;
      P_VAC:   preset = t_vac_q;
      W_ON:    preset = t_water_q;
      W_WAIT:  preset = t_waitw_q;
      W_VAC:   preset = t_vacw_q;
      default: timed  = 1'b0;
    endcase
    // A held phase neither counts nor exits; full-width equality ends it.
    phase_exit = timed && !hold_i && (phase_cnt == preset);
  end

  // Next-state logic; abort of an active run overrides everything.
  always_comb begin
    state_nxt = state;
    run_load  = 1'b0;
    zero_run  = 1'b0;
    cycle_inc = 1'b0;
    fault_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (prec_sel == 2'd3) begin
            fault_nxt = 1'b1;
          end else if (cycles == '0) begin
            zero_run  = 1'b1;
            state_nxt = FIN;
          end else begin
            run_load  = 1'b1;
            state_nxt = P_ON;
          end
        end
      end
      P_ON:   if (phase_exit) state_nxt = P_WAIT;
      P_WAIT: if (phase_exit) state_nxt = P_VAC;
      P_VAC:  if (phase_exit) state_nxt = W_ON;
      W_ON:   if (phase_exit) state_nxt = W_WAIT;
      W_WAIT: if (phase_exit) state_nxt = W_VAC;
      W_VAC: begin
        if (phase_exit) begin
          cycle_inc = 1'b1;
          state_nxt = (cycle_count_inc == cycles_q) ? FIN : P_ON;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cycle_inc = 1'b0;
      fault_nxt = 1'b1;
    end
  end

  // State, phase timer, latched run configuration and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      cycle_count <= '0;
      t_on_q      <= '0;
      t_wait_q    <= '0;
      t_vac_q     <= '0;
      t_water_q   <= '0;
      t_waitw_q   <= '0;
      t_vacw_q    <= '0;
      cycles_q    <= '0;
      sel_q       <= '0;
      valve_prec  <= '0;
      valve_water <= 1'b0;
      valve_vac   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else if (timed && tick && !hold_i && !phase_exit) begin
        phase_cnt <= phase_cnt + TIMER_W'(1);
      end

      if (run_load) begin
        t_on_q    <= t_on;
        t_wait_q  <= t_wait;
        t_vac_q   <= t_vac;
        t_water_q <= t_water;
        t_waitw_q <= t_waitw;
        t_vacw_q  <= t_vacw;
        cycles_q  <= cycles;
        sel_q     <= prec_sel;
      end

      if (run_load || zero_run) begin
        cycle_count <= '0;
      end else if (cycle_inc) begin
        cycle_count <= cycle_count_inc;
      end

      valve_prec  <= (state_nxt == P_ON && !hold_i) ? (3'b001 << sel_nxt) : 3'b000;
      valve_water <= (state_nxt == W_ON) && !hold_i;
      valve_vac   <= (state_nxt == P_VAC) || (state_nxt == W_VAC);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == FIN);
      fault       <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_ald_cycle_sequencer.sv
// Directed bench for ald_cycle_sequencer. Inputs change and outputs are
// sampled on the falling clock edge; tick is generated 2 ns after each rising
// edge with a programmable period in clocks.
module tb_ald_cycle_sequencer;

  localparam int TIMER_W = 32;
  localparam int CYCLE_W = 16;

  logic               clk = 1'b0;
  logic               rst, tick, start, abort;
  logic [1:0]         prec_sel;
  logic [TIMER_W-1:0] t_on, t_wait, t_vac, t_water, t_waitw, t_vacw;
  logic [CYCLE_W-1:0] cycles;
  logic [2:0]         valve_prec;
  logic               valve_water, valve_vac, busy, done, fault;
  logic [CYCLE_W-1:0] cycle_count;
`ifdef ALD_SEQ_HOLD_EN
  logic               hold = 1'b0;
`endif

  ald_cycle_sequencer #(.TIMER_W(TIMER_W), .CYCLE_W(CYCLE_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
`ifdef ALD_SEQ_HOLD_EN
    .hold(hold),
`endif
    .prec_sel(prec_sel),
    .t_on(t_on), .t_wait(t_wait), .t_vac(t_vac),
    .t_water(t_water), .t_waitw(t_waitw), .t_vacw(t_vacw),
    .cycles(cycles),
    .valve_prec(valve_prec), .valve_water(valve_water), .valve_vac(valve_vac),
    .busy(busy), .done(done), .fault(fault), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int tick_period = 4;
  int tick_div    = 0;
  always begin
    @(posedge clk);
    #2;
    tick_div = (tick_div + 1 >= tick_period) ? 0 : tick_div + 1;
    tick     = (tick_div == 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-run observations collected by run_capture.
  int         seg_q[$];
  int         busy_cnt, done_cnt, overlap, prec_ticks, valve_any;
  logic [2:0] first_prec;

  task automatic set_presets(input int v);
    t_on = v; t_wait = v; t_vac = v; t_water = v; t_waitw = v; t_vacw = v;
  endtask

  // Pulse start, then record compressed output segments until busy drops.
  // Codes: 1 precursor, 2 wait, 3 vacuum, 4 water, 5 FIN.
  task automatic run_capture(input int max_cyc);
    int code;
    seg_q.delete();
    busy_cnt = 0; done_cnt = 0; overlap = 0; prec_ticks = 0; valve_any = 0;
    first_prec = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (done) done_cnt++;
      if (valve_prec != 3'b000 && valve_water) overlap++;
      if (valve_prec != 3'b000 && tick) prec_ticks++;
      if (valve_prec != 3'b000 || valve_water || valve_vac) valve_any++;
      if (busy_cnt == 1) first_prec = valve_prec;
      code = done ? 5 : (valve_prec != 3'b000) ? 1 : valve_water ? 4 : valve_vac ? 3 : 2;
      if (seg_q.size() == 0 || seg_q[$] != code) seg_q.push_back(code);
      @(negedge clk);
    end
    check("run_terminated", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seg[13] = '{1, 2, 3, 4, 2, 3, 1, 2, 3, 4, 2, 3, 5};
    int got, rises, held_on, after_on;
    logic prev_water, timed_out;

    rst = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0;
    prec_sel = 2'd0; cycles = '0;
    set_presets(0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valves", {valve_prec, valve_water, valve_vac}, 5'b0);
    check("rst_done_fault", {done, fault}, 2'b0);
    check("rst_cycle_count", cycle_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // Two cycles, all presets 3, precursor 2.
    set_presets(3); cycles = 2; prec_sel = 2'd1;
    run_capture(1000);
    check("t1_seg_len", seg_q.size(), 13);
    for (int i = 0; i < 13; i++) begin
      got = (i < seg_q.size()) ? seg_q[i] : -1;
      check($sformatf("t1_seg%0d", i), got, exp_seg[i]);
    end
    check("t1_first_prec", first_prec, 3'b010);
    check("t1_prec_ticks", prec_ticks, 6);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_overlap", overlap, 0);
    check("t1_cycle_count", cycle_count, 2);

    // Zero presets, one cycle: six one-clock phases plus FIN.
    set_presets(0); cycles = 1; prec_sel = 2'd2;
    run_capture(100);
    check("t2_busy_clks", busy_cnt, 7);
    check("t2_seg_len", seg_q.size(), 7);
    check("t2_first_prec", first_prec, 3'b100);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_cycle_count", cycle_count, 1);

    // Zero cycles: straight to FIN, no valves, count cleared.
    cycles = 0; prec_sel = 2'd0;
    run_capture(100);
    check("t3_busy_clks", busy_cnt, 1);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_valve_any", valve_any, 0);
    check("t3_cycle_count", cycle_count, 0);

    // Invalid precursor select.
    cycles = 2; prec_sel = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_fault_pulse", fault, 1'b1);
    check("t4_busy", busy, 1'b0);
    @(negedge clk);
    check("t4_fault_end", fault, 1'b0);
    check("t4_busy_after", busy, 1'b0);

    // Abort in the middle of W_ON of cycle 2 out of 5.
    set_presets(3); cycles = 5; prec_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; prev_water = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (valve_water && !prev_water) rises++;
      prev_water = valve_water;
      if (rises == 2) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("t5_reach_w_on", timed_out, 1'b0);
    repeat (2) @(negedge clk);
    check("t5_in_w_on", valve_water, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_valves_off", {valve_prec, valve_water, valve_vac}, 5'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_fault", fault, 1'b1);
    check("t5_done", done, 1'b0);
    check("t5_cycle_count", cycle_count, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_restart_busy", busy, 1'b1);
    check("t5_restart_prec", valve_prec, 3'b001);
    check("t5_restart_fault", fault, 1'b0);
    check("t5_restart_count", cycle_count, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort2_fault", fault, 1'b1);

    // Abort while idle overrides start and reports nothing.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("t6_idle_abort_busy", busy, 1'b0);
    check("t6_idle_abort_fault", fault, 1'b0);
    @(negedge clk);

`ifdef ALD_SEQ_HOLD_EN
    // Hold P_ON at count 4 of 10 for 20 ticks, with a tick every clock.
    tick_period = 1;
    set_presets(0); t_on = 10; cycles = 1; prec_sel = 2'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("h_prec_before", valve_prec, 3'b100);
    hold = 1'b1;
    held_on = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valve_prec != 3'b000 || valve_vac) held_on++;
    end
    check("h_prec_during", held_on, 0);
    check("h_busy_during", busy, 1'b1);
    hold = 1'b0;
    after_on = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valve_prec == 3'b000) break;
      after_on++;
    end
    check("h_after_release", after_on, 6);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    check("h_run_end", busy, 1'b0);
    tick_period = 4;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
